// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds architectural HI/LO and models the
// multi-cycle latency of MULT/MULTU/DIV/DIVU, with MTHI/MTLO writes and stall generation.
module mdu_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RdSel,
    input  logic        UsesMD,
    output logic        Busy,
    output logic        StallReq,
    output logic [31:0] HiloOut
);

    localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t        state_q = S_IDLE;
    state_t        state_d;
    logic [CW-1:0] cnt_q = '0;
    logic [CW-1:0] cnt_d;
    logic [31:0]   hi_q = '0;
    logic [31:0]   hi_d;
    logic [31:0]   lo_q = '0;
    logic [31:0]   lo_d;
    logic [31:0]   pend_hi_q = '0;
    logic [31:0]   pend_hi_d;
    logic [31:0]   pend_lo_q = '0;
    logic [31:0]   pend_lo_d;

    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        op_valid;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of hitting an overflow corner in the divider.
    always_comb begin
        is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        a_ext     = {{32{is_signed & A[31]}}, A};
        b_ext     = {{32{is_signed & B[31]}}, B};
        product   = a_ext * b_ext;
        a_neg     = is_signed & A[31];
        b_neg     = is_signed & B[31];
        a_mag     = a_neg ? (32'd0 - A) : A;
        b_mag     = b_neg ? (32'd0 - B) : B;
        b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag     = a_mag / b_safe;
        r_mag     = a_mag % b_safe;
        quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem       = a_neg ? (32'd0 - r_mag) : r_mag;
        op_valid  = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (op_valid) begin
                        if (MDOp == OP_MULT || MDOp == OP_MULTU) begin
                            pend_hi_d = product[63:32];
                            pend_lo_d = product[31:0];
                            cnt_d     = CW'(MUL_CYC);
                            state_d   = S_MUL;
                        end else begin
                            // Divide by zero commits the current HI/LO, i.e. no change.
                            pend_hi_d = (B == 32'd0) ? hi_q : rem;
                            pend_lo_d = (B == 32'd0) ? lo_q : quot;
                            cnt_d     = CW'(DIV_CYC);
                            state_d   = S_DIV;
                        end
                    end
                end else if (MDOp == OP_MTHI) begin
                    hi_d = A;
                end else if (MDOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign StallReq = UsesMD & (Busy | Start);
    assign HiloOut  = RdSel ? hi_q : lo_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL expose parameter MUL_CYC, default 5, meaning Busy cycles for MULT/MULTU.
REQ-002 SHALL expose parameter DIV_CYC, default 10, meaning Busy cycles for DIV/DIVU.
REQ-003 SHALL have port Clk  input  1  clock, rising-edge.
REQ-004 SHALL have port Reset  input  1  reset Reset, synchronous, active-high; clock Clk.
REQ-005 SHALL have port Start  input  1  E-stage holds a valid MULT/MULTU/DIV/DIVU.
REQ-006 SHALL have port MDOp  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
REQ-007 SHALL have port A  input  32  rs operand (forwarded).
REQ-008 SHALL have port B  input  32  rt operand (forwarded).
REQ-009 SHALL have port RdSel  input  1  HiloOut source: 0 LO, 1 HI.
REQ-010 SHALL have port UsesMD  input  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port Busy  output  1  operation in flight.
REQ-012 SHALL have port StallReq  output  1  D-stage stall request to hazard unit.
REQ-013 SHALL have port HiloOut  output  32  selected architectural HI or LO.

Function
REQ-014 SHALL hold architectural HI, LO (32 each), a pending result pair, a down-counter, and state in {IDLE, MUL, DIV}.
REQ-015 SHALL accept an operation only when state==IDLE and Start==1 and MDOp in {001..100}; accepted at edge E0.
REQ-016 At E0, SHALL latch the full result into the pending pair, load counter with MUL_CYC or DIV_CYC, enter MUL or DIV.
REQ-017 Busy SHALL be 1 exactly while state!=IDLE: MUL_CYC cycles for multiply, DIV_CYC cycles for divide, after E0.
REQ-018 Counter SHALL decrement each edge while busy; at the edge it reaches 0, SHALL copy pending pair into HI/LO and return to IDLE.
REQ-019 HI/LO SHALL be unchanged while busy; HiloOut SHALL reflect old values until the completion edge.
REQ-020 MULT: {HI,LO} = signed 64-bit A*B; MULTU: unsigned 64-bit A*B.
REQ-021 DIV: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; DIVU: unsigned quotient/remainder.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 Divide by zero (B==0) SHALL run full DIV_CYC with Busy, and SHALL leave HI/LO unchanged at completion.
REQ-024 MTHI/MTLO with state IDLE and Start==0 SHALL write A into HI/LO at the next edge; no Busy.
REQ-025 Start or MTHI/MTLO while busy SHALL be ignored (no state, counter, HI/LO change).
REQ-026 Start==1 with MDOp in {000,101,110,111} SHALL be ignored; MDOp 111 SHALL also not write HI/LO.
REQ-027 StallReq SHALL equal UsesMD & (Busy | Start), combinational.
REQ-028 HiloOut SHALL be RdSel ? HI : LO, combinational, no bypass of same-cycle MTHI/MTLO.
REQ-029 Completion edge and a new Start in that same cycle: Start SHALL be ignored (state not yet IDLE).

Reset
REQ-030 On Reset at an edge: HI=0, LO=0, pending=0, counter=0, state=IDLE; Busy=0 after that edge.
REQ-031 Reset SHALL take priority over Start, MTHI/MTLO and completion; an in-flight operation is discarded and never committed.
REQ-032 Until first reset, all registers SHALL initialise to the reset values.

Verification
REQ-033 MULT A=0xFFFFFFFE (-2), B=3 -> Busy 5 cycles; after completion HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-034 DIV A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-035 Busy MULT with UsesMD=1 (mflo in D) -> StallReq=1 for all 5 cycles and in the Start cycle; 0 in the cycle after completion with HiloOut(RdSel=0) = new LO.
REQ-036 MTHI A=0x12345678 while idle -> HI=0x12345678 next cycle; MTLO issued mid-DIV -> LO unchanged; DIV B=0 -> Busy 10 cycles, HI/LO keep prior values.
REQ-037 Reset asserted on cycle 3 of a DIV -> Busy=0, HI=LO=0 after that edge; no later commit; new MULT accepted next cycle.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; Start asserted on completion cycle -> ignored, Busy=0 afterwards.
